// File: rtl/fcmp_pipe.sv
// Two-stage pipelined floating-point compare/select unit (EQ/LT/LE/MIN/MAX).
// Stage 1 registers the order-preserving keys and the operands, stage 2 registers the result.
// Optional NaN handling is compiled in when the macro FCMP_NAN_EN is defined; otherwise NaNs are
// ordered by key like any other encoding and nan_flag_o is tied low.
module fcmp_pipe #(
  parameter int unsigned EW = 8,
  parameter int unsigned MW = 23,
  localparam int unsigned W = 1 + EW + MW
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [2:0]   op_i,
  input  logic [W-1:0] x1_i,
  input  logic [W-1:0] x2_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] y_o,
  output logic         nan_flag_o
);

  localparam logic [2:0] OpEq  = 3'd0;
  localparam logic [2:0] OpLt  = 3'd1;
  localparam logic [2:0] OpLe  = 3'd2;
  localparam logic [2:0] OpMin = 3'd3;
  localparam logic [2:0] OpMax = 3'd4;

  // Map an encoding to an unsigned key whose order equals numeric order; denormals flush to zero.
  function automatic logic [W-1:0] key_of(input logic [W-1:0] x);
    logic [EW-1:0] e;
    logic [MW-1:0] m;
    e = x[MW +: EW];
    m = x[MW-1:0];
    if (e == '0)          key_of = {1'b1, {(EW + MW){1'b0}}};
    else if (!x[W-1])     key_of = {1'b1, e, m};
    else                  key_of = {1'b0, ~e, ~m};
  endfunction

  logic         s1_valid_q;
  logic [W-1:0] k1_q, k2_q, x1_q, x2_q;
  logic [2:0]   op_q;
  logic         out_valid_q;
  logic [W-1:0] y_q, y_d;
  logic         s2_ready;
  logic         accept;

  assign s2_ready   = !out_valid_q || out_ready_i;
  assign in_ready_o = !s1_valid_q || s2_ready;
  assign accept     = in_valid_i && in_ready_o;

`ifdef FCMP_NAN_EN
  localparam logic [W-1:0] QNan = {1'b0, {EW{1'b1}}, 1'b1, {(MW - 1){1'b0}}};

  function automatic logic is_nan(input logic [W-1:0] x);
    is_nan = (&x[MW +: EW]) && (|x[MW-1:0]);
  endfunction

  logic nan1_q, nan2_q;
  logic nan_q, nan_d;

  // Stage 1 NaN bits travel alongside the keys.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      nan1_q <= 1'b0;
      nan2_q <= 1'b0;
    end else if (accept) begin
      nan1_q <= is_nan(x1_i);
      nan2_q <= is_nan(x2_i);
    end
  end

  // Stage 2 NaN flag, held while the output is stalled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      nan_q <= 1'b0;
    end else if (s2_ready && s1_valid_q) begin
      nan_q <= nan_d;
    end
  end

  assign nan_flag_o = nan_q;
`else
  assign nan_flag_o = 1'b0;
`endif

  // Stage 1: capture keys, operands and opcode on accept; valid advances whenever space exists.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q <= 1'b0;
      k1_q       <= '0;
      k2_q       <= '0;
      x1_q       <= '0;
      x2_q       <= '0;
      op_q       <= '0;
    end else begin
      if (in_ready_o) s1_valid_q <= in_valid_i;
      if (accept) begin
        k1_q <= key_of(x1_i);
        k2_q <= key_of(x2_i);
        x1_q <= x1_i;
        x2_q <= x2_i;
        op_q <= op_i;
      end
    end
  end

  // Result selection from the stage 1 keys; ties in MIN/MAX return x1.
  always_comb begin
    y_d = '0;
`ifdef FCMP_NAN_EN
    nan_d = 1'b0;
`endif
    case (op_q)
      OpEq:    y_d = {{(W - 1){1'b0}}, k1_q == k2_q};
      OpLt:    y_d = {{(W - 1){1'b0}}, k1_q <  k2_q};
      OpLe:    y_d = {{(W - 1){1'b0}}, k1_q <= k2_q};
      OpMin:   y_d = (k2_q < k1_q) ? x2_q : x1_q;
      OpMax:   y_d = (k2_q > k1_q) ? x2_q : x1_q;
      default: y_d = '0;
    endcase
`ifdef FCMP_NAN_EN
    if ((op_q == OpEq || op_q == OpLt || op_q == OpLe) && (nan1_q || nan2_q)) begin
      y_d   = '0;
      nan_d = 1'b1;
    end else if ((op_q == OpMin || op_q == OpMax) && (nan1_q || nan2_q)) begin
      nan_d = 1'b1;
      if (nan1_q && nan2_q) y_d = QNan;
      else if (nan1_q)      y_d = x2_q;
      else                  y_d = x1_q;
    end
`endif
  end

  // Stage 2: result register, frozen while downstream stalls.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      y_q         <= '0;
    end else if (s2_ready) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) y_q <= y_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign y_o         = y_q;

endmodule

// File: tb/tb_fcmp_pipe.sv
// Self-checking bench for fcmp_pipe: single-precision instance plus a half-precision instance.
module tb_fcmp_pipe;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
    logic        nan;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, nan_flag;
  logic [2:0]  op;
  logic [31:0] x1, x2, y;

  logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready, h_nan;
  logic [2:0]  h_op;
  logic [15:0] h_x1, h_x2, h_y;

  vec_t sb[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  fcmp_pipe #(.EW(8), .MW(23)) dut (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready), .op_i(op),
    .x1_i(x1), .x2_i(x2), .out_valid_o(out_valid), .out_ready_i(out_ready), .y_o(y),
    .nan_flag_o(nan_flag)
  );

  fcmp_pipe #(.EW(5), .MW(10)) dut_h (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(h_in_valid), .in_ready_o(h_in_ready), .op_i(h_op),
    .x1_i(h_x1), .x2_i(h_x2), .out_valid_o(h_out_valid), .out_ready_i(h_out_ready), .y_o(h_y),
    .nan_flag_o(h_nan)
  );

  task automatic test_reset;
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    tests++; if (y !== 32'h0) begin fails++; $display("FAIL reset_y got %h want 0", y); end
    tests++; if (nan_flag !== 1'b0) begin fails++; $display("FAIL reset_nan got %b want 0", nan_flag); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One op at a time, checking two-cycle latency and result against the scoreboard.
  task automatic test_compare;
    vec_t v[5];
    vec_t e;
    v[0] = '{3'd2, 32'h3F800000, 32'h40000000, 32'h1, 1'b0};
    v[1] = '{3'd1, 32'hBF800000, 32'h3F800000, 32'h1, 1'b0};
    v[2] = '{3'd1, 32'h40000000, 32'h3F800000, 32'h0, 1'b0};
    v[3] = '{3'd0, 32'h80000000, 32'h00000001, 32'h1, 1'b0};
    v[4] = '{3'd3, 32'h00000000, 32'h80000000, 32'h0, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; op = v[i].op; x1 = v[i].a; x2 = v[i].b;
      #1;
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL cmp_accept[%0d] got %b want 1", i, in_ready); end
      sb.push_back(v[i]);
      @(negedge clk);
      in_valid = 1'b0;
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL cmp_early[%0d] got %b want 0", i, out_valid); end
      @(negedge clk);
      tests++;
      if (out_valid !== 1'b1) begin
        fails++; $display("FAIL cmp_latency[%0d] got %b want 1", i, out_valid);
      end else begin
        e = sb.pop_front();
        tests++; if (y !== e.y) begin fails++; $display("FAIL cmp_y[%0d] got %h want %h", i, y, e.y); end
        tests++; if (nan_flag !== e.nan) begin fails++; $display("FAIL cmp_nan[%0d] got %b want %b", i, nan_flag, e.nan); end
      end
      sb.delete();
    end
  endtask

  task automatic test_nan;
    vec_t v[4];
    vec_t e;
`ifdef FCMP_NAN_EN
    v[0] = '{3'd2, 32'h7FC00000, 32'h3F800000, 32'h0,        1'b1};
    v[1] = '{3'd4, 32'h7FC00000, 32'h3F800000, 32'h3F800000, 1'b1};
    v[2] = '{3'd3, 32'h7FC00001, 32'hFF800001, 32'h7FC00000, 1'b1};
    v[3] = '{3'd3, 32'h3F800000, 32'h7FC00000, 32'h3F800000, 1'b1};
`else
    v[0] = '{3'd2, 32'h7FC00000, 32'h3F800000, 32'h0,        1'b0};
    v[1] = '{3'd4, 32'h7FC00000, 32'h3F800000, 32'h7FC00000, 1'b0};
    v[2] = '{3'd3, 32'h7FC00001, 32'hFF800001, 32'hFF800001, 1'b0};
    v[3] = '{3'd3, 32'h3F800000, 32'h7FC00000, 32'h3F800000, 1'b0};
`endif
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1; op = v[i].op; x1 = v[i].a; x2 = v[i].b;
      sb.push_back(v[i]);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      tests++;
      if (out_valid !== 1'b1) begin
        fails++; $display("FAIL nan_latency[%0d] got %b want 1", i, out_valid);
      end else begin
        e = sb.pop_front();
        tests++; if (y !== e.y) begin fails++; $display("FAIL nan_y[%0d] got %h want %h", i, y, e.y); end
        tests++; if (nan_flag !== e.nan) begin fails++; $display("FAIL nan_flag[%0d] got %b want %b", i, nan_flag, e.nan); end
      end
      sb.delete();
    end
  endtask

  // Eight ops streamed with out_ready low for three cycles; in_ready and hold checked every cycle.
  task automatic test_back_to_back;
    vec_t        stim[8];
    vec_t        e;
    int          idx, outstanding;
    bit          held, saw_stall, exp_ready;
    logic [31:0] held_y;
    stim[0] = '{3'd2, 32'h3F800000, 32'h40000000, 32'h1,        1'b0};
    stim[1] = '{3'd1, 32'hBF800000, 32'h3F800000, 32'h1,        1'b0};
    stim[2] = '{3'd1, 32'h40000000, 32'h3F800000, 32'h0,        1'b0};
    stim[3] = '{3'd0, 32'h80000000, 32'h00000001, 32'h1,        1'b0};
    stim[4] = '{3'd3, 32'h00000000, 32'h80000000, 32'h0,        1'b0};
    stim[5] = '{3'd4, 32'h3F800000, 32'hC0000000, 32'h3F800000, 1'b0};
    stim[6] = '{3'd3, 32'h40400000, 32'hBF800000, 32'hBF800000, 1'b0};
    stim[7] = '{3'd0, 32'h3F800000, 32'h3F800000, 32'h1,        1'b0};
    sb.delete();
    idx = 0; outstanding = 0; held = 1'b0; saw_stall = 1'b0; held_y = '0;
    for (int cyc = 0; cyc < 60 && !(idx == 8 && outstanding == 0); cyc++) begin
      @(negedge clk);
      in_valid  = (idx < 8);
      if (idx < 8) begin op = stim[idx].op; x1 = stim[idx].a; x2 = stim[idx].b; end
      out_ready = !(cyc >= 3 && cyc <= 5);
      #1;
      if (held) begin
        tests++; if (y !== held_y) begin fails++; $display("FAIL b2b_hold cyc %0d got %h want %h", cyc, y, held_y); end
      end
      exp_ready = (outstanding < 2) || out_ready;
      tests++;
      if (in_ready !== exp_ready) begin
        fails++; $display("FAIL b2b_in_ready cyc %0d got %b want %b", cyc, in_ready, exp_ready);
      end
      if (!in_ready) saw_stall = 1'b1;
      if (out_valid && out_ready) begin
        tests++;
        if (sb.size() == 0) begin
          fails++; $display("FAIL b2b_extra_output cyc %0d got %h want none", cyc, y);
        end else begin
          e = sb.pop_front();
          outstanding--;
          if (y !== e.y) begin fails++; $display("FAIL b2b_y cyc %0d got %h want %h", cyc, y, e.y); end
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(stim[idx]);
        idx++;
        outstanding++;
      end
      held   = out_valid && !out_ready;
      held_y = y;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tests++; if (saw_stall !== 1'b1) begin fails++; $display("FAIL b2b_stall got %b want 1", saw_stall); end
    tests++; if (idx != 8) begin fails++; $display("FAIL b2b_sent got %0d want 8", idx); end
    tests++; if (outstanding != 0) begin fails++; $display("FAIL b2b_drained got %0d want 0", outstanding); end
    sb.delete();
  endtask

  // Fill both stages, reset asynchronously, then confirm the pipe restarts cleanly.
  task automatic test_reset_inflight;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; op = 3'd2; x1 = 32'h3F800000; x2 = 32'h40000000;
    @(negedge clk);
    op = 3'd1; x1 = 32'hBF800000; x2 = 32'h3F800000;
    @(negedge clk);
    in_valid = 1'b0;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL rst_full_in_ready got %b want 0", in_ready); end
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL rst_full_out_valid got %b want 1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_async_out_valid got %b want 0", out_valid); end
    tests++; if (y !== 32'h0) begin fails++; $display("FAIL rst_async_y got %h want 0", y); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_async_in_ready got %b want 1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    in_valid = 1'b1; op = 3'd0; x1 = 32'h80000000; x2 = 32'h00000001;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_after_in_ready got %b want 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_after_early got %b want 0", out_valid); end
    @(negedge clk);
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL rst_after_valid got %b want 1", out_valid); end
    tests++; if (y !== 32'h1) begin fails++; $display("FAIL rst_after_y got %h want 1", y); end
  endtask

  task automatic test_half;
    h_out_ready = 1'b1;
    @(negedge clk);
    h_in_valid = 1'b1; h_op = 3'd4; h_x1 = 16'h3C00; h_x2 = 16'hC000;
    @(negedge clk);
    h_op = 3'd6; h_x1 = 16'h3C00; h_x2 = 16'h3C00;
    @(negedge clk);
    h_in_valid = 1'b0;
    tests++; if (h_out_valid !== 1'b1) begin fails++; $display("FAIL half_max_valid got %b want 1", h_out_valid); end
    tests++; if (h_y !== 16'h3C00) begin fails++; $display("FAIL half_max_y got %h want 3c00", h_y); end
    @(negedge clk);
    tests++; if (h_out_valid !== 1'b1) begin fails++; $display("FAIL half_rsvd_valid got %b want 1", h_out_valid); end
    tests++; if (h_y !== 16'h0) begin fails++; $display("FAIL half_rsvd_y got %h want 0", h_y); end
    tests++; if (h_nan !== 1'b0) begin fails++; $display("FAIL half_rsvd_nan got %b want 0", h_nan); end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; op = '0; x1 = '0; x2 = '0; out_ready = 1'b1;
    h_in_valid = 1'b0; h_op = '0; h_x1 = '0; h_x2 = '0; h_out_ready = 1'b1;
    test_reset();
    test_compare();
    test_nan();
    test_back_to_back();
    test_reset_inflight();
    test_half();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
